// File: rtl/mem_access.sv
// Memory-access pipeline stage: issues data-memory loads/stores over a req/ack
// handshake, stalls execute while a transaction is outstanding, and registers MEM/WB.
module mem_access #(
    parameter int ADDR_WIDTH = 18
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           result_in,
    input  logic [4:0]            write_reg_in,
    input  logic                  reg_write_in,
    input  logic                  writef_in,
    input  logic                  mem_read_in,
    input  logic                  mem_write_in,
    input  logic [31:0]           mem_write_data,
    input  logic [31:0]           pc_in,
    input  logic                  wait_exec_in,
    output logic                  wait_mem,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [ADDR_WIDTH-1:0] dmem_addr,
    output logic [31:0]           dmem_wdata,
    input  logic [31:0]           dmem_rdata,
    input  logic                  dmem_ack,
    output logic [31:0]           result_mem,
    output logic [4:0]            write_reg_mem,
    output logic                  reg_write_mem,
    output logic                  writef_mem,
    output logic [31:0]           pc_mem
);

    typedef enum logic {IDLE, BUSY} state_e;

    state_e                state_q, state_d;
    logic                  dmemReq_q, dmemReq_d;
    logic                  dmemWe_q, dmemWe_d;
    logic [ADDR_WIDTH-1:0] dmemAddr_q, dmemAddr_d;
    logic [31:0]           dmemWdata_q, dmemWdata_d;
    logic [31:0]           resultMem_q, resultMem_d;
    logic [4:0]            writeRegMem_q, writeRegMem_d;
    logic                  regWriteMem_q, regWriteMem_d;
    logic                  writefMem_q, writefMem_d;
    logic [31:0]           pcMem_q, pcMem_d;

    // Writeback fields of the instruction waiting on memory
    logic [4:0]            pendReg_q, pendReg_d;
    logic                  pendRegWrite_q, pendRegWrite_d;
    logic                  pendWritef_q, pendWritef_d;
    logic [31:0]           pendPc_q, pendPc_d;
    logic                  pendIsWrite_q, pendIsWrite_d;

    logic                  memOp;

    assign memOp    = (mem_read_in | mem_write_in) & ~wait_exec_in;
    assign wait_mem = ((state_q == IDLE) & memOp) | ((state_q == BUSY) & ~dmem_ack);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            dmemReq_q      <= 1'b0;
            dmemWe_q       <= 1'b0;
            dmemAddr_q     <= '0;
            dmemWdata_q    <= '0;
            resultMem_q    <= '0;
            writeRegMem_q  <= '0;
            regWriteMem_q  <= 1'b0;
            writefMem_q    <= 1'b0;
            pcMem_q        <= '0;
            pendReg_q      <= '0;
            pendRegWrite_q <= 1'b0;
            pendWritef_q   <= 1'b0;
            pendPc_q       <= '0;
            pendIsWrite_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            dmemReq_q      <= dmemReq_d;
            dmemWe_q       <= dmemWe_d;
            dmemAddr_q     <= dmemAddr_d;
            dmemWdata_q    <= dmemWdata_d;
            resultMem_q    <= resultMem_d;
            writeRegMem_q  <= writeRegMem_d;
            regWriteMem_q  <= regWriteMem_d;
            writefMem_q    <= writefMem_d;
            pcMem_q        <= pcMem_d;
            pendReg_q      <= pendReg_d;
            pendRegWrite_q <= pendRegWrite_d;
            pendWritef_q   <= pendWritef_d;
            pendPc_q       <= pendPc_d;
            pendIsWrite_q  <= pendIsWrite_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        dmemReq_d      = dmemReq_q;
        dmemWe_d       = dmemWe_q;
        dmemAddr_d     = dmemAddr_q;
        dmemWdata_d    = dmemWdata_q;
        resultMem_d    = resultMem_q;
        writeRegMem_d  = writeRegMem_q;
        regWriteMem_d  = regWriteMem_q;
        writefMem_d    = writefMem_q;
        pcMem_d        = pcMem_q;
        pendReg_d      = pendReg_q;
        pendRegWrite_d = pendRegWrite_q;
        pendWritef_d   = pendWritef_q;
        pendPc_d       = pendPc_q;
        pendIsWrite_d  = pendIsWrite_q;

        unique case (state_q)
            IDLE: begin
                dmemReq_d = 1'b0;
                if (wait_exec_in || memOp) begin
                    // Execute output not valid yet, or the op now moves to memory
                    resultMem_d   = '0;
                    writeRegMem_d = '0;
                    regWriteMem_d = 1'b0;
                    writefMem_d   = 1'b0;
                    pcMem_d       = '0;
                end else begin
                    resultMem_d   = result_in;
                    writeRegMem_d = write_reg_in;
                    regWriteMem_d = reg_write_in;
                    writefMem_d   = writef_in;
                    pcMem_d       = pc_in;
                end
                if (memOp) begin
                    state_d        = BUSY;
                    dmemReq_d      = 1'b1;
                    dmemWe_d       = mem_write_in;
                    dmemAddr_d     = result_in[ADDR_WIDTH+1:2];
                    dmemWdata_d    = mem_write_data;
                    pendReg_d      = write_reg_in;
                    pendRegWrite_d = reg_write_in;
                    pendWritef_d   = writef_in;
                    pendPc_d       = pc_in;
                    pendIsWrite_d  = mem_write_in;
                end
            end
            BUSY: begin
                if (dmem_ack) begin
                    state_d       = IDLE;
                    dmemReq_d     = 1'b0;
                    resultMem_d   = pendIsWrite_q ? 32'd0 : dmem_rdata;
                    writeRegMem_d = pendReg_q;
                    regWriteMem_d = pendRegWrite_q;
                    writefMem_d   = pendWritef_q;
                    pcMem_d       = pendPc_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign dmem_req      = dmemReq_q;
    assign dmem_we       = dmemWe_q;
    assign dmem_addr     = dmemAddr_q;
    assign dmem_wdata    = dmemWdata_q;
    assign result_mem    = resultMem_q;
    assign write_reg_mem = writeRegMem_q;
    assign reg_write_mem = regWriteMem_q;
    assign writef_mem    = writefMem_q;
    assign pc_mem        = pcMem_q;

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: directed ops push expected writebacks and memory
// transactions; a responder models the memory and a monitor checks MEM/WB.
module tb_mem_access;

    localparam int AW = 18;

    typedef struct {
        logic [31:0] result;
        logic [4:0]  wreg;
        logic        rw;
        logic        wf;
        logic [31:0] pc;
    } wbExp_t;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        int            delay;
        logic [31:0]   rdata;
    } memTxn_t;

    logic          clk;
    logic          rst;
    logic [31:0]   resultIn;
    logic [4:0]    writeRegIn;
    logic          regWriteIn;
    logic          writefIn;
    logic          memReadIn;
    logic          memWriteIn;
    logic [31:0]   memWriteData;
    logic [31:0]   pcIn;
    logic          waitExecIn;
    logic          waitMem;
    logic          dmemReq;
    logic          dmemWe;
    logic [AW-1:0] dmemAddr;
    logic [31:0]   dmemWdata;
    logic [31:0]   dmemRdata;
    logic          dmemAck;
    logic [31:0]   resultMem;
    logic [4:0]    writeRegMem;
    logic          regWriteMem;
    logic          writefMem;
    logic [31:0]   pcMem;

    logic          ackResp, ackStray;
    logic [31:0]   respData, strayData;
    logic          monitorOn;

    int compareCount = 0;
    int failCount    = 0;

    wbExp_t  sbQ[$];
    memTxn_t memQ[$];

    assign dmemAck   = ackResp | ackStray;
    assign dmemRdata = ackStray ? strayData : respData;

    mem_access #(.ADDR_WIDTH(AW)) dut (
        .clk            (clk),
        .rst            (rst),
        .result_in      (resultIn),
        .write_reg_in   (writeRegIn),
        .reg_write_in   (regWriteIn),
        .writef_in      (writefIn),
        .mem_read_in    (memReadIn),
        .mem_write_in   (memWriteIn),
        .mem_write_data (memWriteData),
        .pc_in          (pcIn),
        .wait_exec_in   (waitExecIn),
        .wait_mem       (waitMem),
        .dmem_req       (dmemReq),
        .dmem_we        (dmemWe),
        .dmem_addr      (dmemAddr),
        .dmem_wdata     (dmemWdata),
        .dmem_rdata     (dmemRdata),
        .dmem_ack       (dmemAck),
        .result_mem     (resultMem),
        .write_reg_mem  (writeRegMem),
        .reg_write_mem  (regWriteMem),
        .writef_mem     (writefMem),
        .pc_mem         (pcMem)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compareCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic driveInputs(input logic [31:0] res, input logic [4:0] wreg, input logic rw,
                               input logic wf, input logic rd, input logic wr,
                               input logic [31:0] wdata, input logic [31:0] pc, input logic wexec);
        resultIn     = res;
        writeRegIn   = wreg;
        regWriteIn   = rw;
        writefIn     = wf;
        memReadIn    = rd;
        memWriteIn   = wr;
        memWriteData = wdata;
        pcIn         = pc;
        waitExecIn   = wexec;
    endtask

    task automatic applyIdle(input int cycles);
        repeat (cycles) begin
            @(negedge clk);
            driveInputs('0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        end
    endtask

    // Present one instruction, hold it while wait_mem is high, and measure the stall length
    task automatic applyStimulus(input string name, input logic [31:0] res, input logic [4:0] wreg,
                                 input logic rw, input logic wf, input logic rd, input logic wr,
                                 input logic [31:0] wdata, input logic [31:0] pc, input logic wexec,
                                 input logic [AW-1:0] expAddr, input int delay,
                                 input logic [31:0] rdata, input logic [31:0] expResult,
                                 input bit expWb, input int expWait);
        int  waitCnt;
        bit  done;
        bit  stalled;
        wbExp_t  wb;
        memTxn_t mt;
        if (expWb) begin
            wb.result = expResult; wb.wreg = wreg; wb.rw = rw; wb.wf = wf; wb.pc = pc;
            sbQ.push_back(wb);
        end
        if ((rd | wr) & ~wexec) begin
            mt.we = wr; mt.addr = expAddr; mt.wdata = wdata; mt.delay = delay; mt.rdata = rdata;
            memQ.push_back(mt);
        end
        @(negedge clk);
        driveInputs(res, wreg, rw, wf, rd, wr, wdata, pc, wexec);
        waitCnt = 0;
        done    = 0;
        for (int c = 0; c < 50; c++) begin
            #4;
            stalled = waitMem;
            @(posedge clk);
            if (!stalled) begin
                done = 1;
                break;
            end
            waitCnt++;
            @(negedge clk);
        end
        if (!done) begin
            compareCount++;
            failCount++;
            $display("[TB] FAIL %s_accept: got timeout expected accept within 50 cycles", name);
        end else begin
            checkOutput({name, "_waitCycles"}, waitCnt, expWait);
        end
    endtask

    // Memory responder: checks each request and acks after its programmed number of BUSY cycles
    initial begin
        memTxn_t cur;
        bit      active;
        int      cnt;
        ackResp  = 1'b0;
        respData = '0;
        active   = 0;
        cnt      = 0;
        cur      = '{we: 1'b0, addr: '0, wdata: '0, delay: 0, rdata: '0};
        forever begin
            @(negedge clk);
            if (ackResp) begin
                ackResp = 1'b0;
                active  = 0;
            end else if (active && dmemReq !== 1'b1) begin
                active = 0;
            end
            if (!active && dmemReq === 1'b1 && monitorOn) begin
                if (memQ.size() == 0) begin
                    compareCount++;
                    failCount++;
                    $display("[TB] FAIL unexpected_req: got dmem_req=1 addr=0x%05h expected no request", dmemAddr);
                end else begin
                    cur = memQ.pop_front();
                    checkOutput("dmem_we", dmemWe, cur.we);
                    checkOutput("dmem_addr", dmemAddr, cur.addr);
                    checkOutput("dmem_wdata", dmemWdata, cur.wdata);
                    active = 1;
                    cnt    = 0;
                end
            end
            if (active) begin
                cnt++;
                if (cnt == cur.delay) begin
                    ackResp  = 1'b1;
                    respData = cur.rdata;
                end
            end
        end
    end

    // MEM/WB monitor: any nonzero pc_mem is a completed instruction; pc_mem=0 is a bubble
    initial begin
        wbExp_t e;
        wait (monitorOn);
        forever begin
            @(negedge clk);
            if (pcMem !== 32'd0) begin
                if (sbQ.size() == 0) begin
                    compareCount++;
                    failCount++;
                    $display("[TB] FAIL unexpected_wb: got pc_mem=0x%08h expected bubble", pcMem);
                end else begin
                    e = sbQ.pop_front();
                    checkOutput("wb_pc", pcMem, e.pc);
                    checkOutput("wb_result", resultMem, e.result);
                    checkOutput("wb_write_reg", {27'd0, writeRegMem}, {27'd0, e.wreg});
                    checkOutput("wb_reg_write", {31'd0, regWriteMem}, {31'd0, e.rw});
                    checkOutput("wb_writef", {31'd0, writefMem}, {31'd0, e.wf});
                end
            end else begin
                checkOutput("bubble_reg_write", {31'd0, regWriteMem}, 32'd0);
            end
        end
    end

    initial begin
        monitorOn = 1'b0;
        ackStray  = 1'b0;
        strayData = '0;
        rst       = 1'b1;
        driveInputs('0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_dmem_req", {31'd0, dmemReq}, 32'd0);
        checkOutput("rst_dmem_we", {31'd0, dmemWe}, 32'd0);
        checkOutput("rst_dmem_addr", {14'd0, dmemAddr}, 32'd0);
        checkOutput("rst_dmem_wdata", dmemWdata, 32'd0);
        checkOutput("rst_result_mem", resultMem, 32'd0);
        checkOutput("rst_reg_write_mem", {31'd0, regWriteMem}, 32'd0);
        checkOutput("rst_pc_mem", pcMem, 32'd0);
        checkOutput("rst_wait_mem", {31'd0, waitMem}, 32'd0);
        rst       = 1'b0;
        monitorOn = 1'b1;

        // ALU pass-through
        applyStimulus("alu", 32'h0000_1234, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0100, 1'b0,
                      18'h0, 0, 32'h0, 32'h0000_1234, 1'b1, 0);
        // FP load, ack in third BUSY cycle
        applyStimulus("load", 32'h0000_0010, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0000_0104, 1'b0,
                      18'h00004, 3, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 3);
        // Store, ack in first BUSY cycle
        applyStimulus("store", 32'h0000_0020, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hCAFE_0001, 32'h0000_0108, 1'b0,
                      18'h00008, 1, 32'h1111_2222, 32'h0, 1'b1, 1);
        // Execute busy: load request must become a bubble with no memory access
        applyStimulus("wexec", 32'h0000_0030, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_010C, 1'b1,
                      18'h0, 0, 32'h0, 32'h0, 1'b0, 0);
        // Read and write both set with reg_write: write wins, result is 0
        applyStimulus("rdwr", 32'h0000_0047, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0BAD_F00D, 32'h0000_0110, 1'b0,
                      18'h00011, 2, 32'h7777_7777, 32'h0, 1'b1, 2);
        // Back-to-back loads, the second with high and byte-offset address bits set
        applyStimulus("b2b_ld1", 32'h0000_0100, 5'd10, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_0114, 1'b0,
                      18'h00040, 1, 32'h0000_AAAA, 32'h0000_AAAA, 1'b1, 1);
        applyStimulus("b2b_ld2", 32'hABCD_5678, 5'd11, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_0118, 1'b0,
                      18'h3559E, 1, 32'h0000_BBBB, 32'h0000_BBBB, 1'b1, 1);
        applyIdle(2);

        // Abort a load with reset, then deliver a stray ack while idle
        memQ.push_back('{we: 1'b0, addr: 18'h00010, wdata: 32'h0, delay: 100, rdata: 32'h0});
        @(negedge clk);
        driveInputs(32'h0000_0040, 5'd2, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_0200, 1'b0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("abort_req_issued", {31'd0, dmemReq}, 32'd1);
        rst = 1'b1;
        driveInputs('0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort_dmem_req", {31'd0, dmemReq}, 32'd0);
        checkOutput("abort_result_mem", resultMem, 32'd0);
        checkOutput("abort_write_reg_mem", {27'd0, writeRegMem}, 32'd0);
        checkOutput("abort_reg_write_mem", {31'd0, regWriteMem}, 32'd0);
        checkOutput("abort_pc_mem", pcMem, 32'd0);
        ackStray  = 1'b1;
        strayData = 32'h5555_AAAA;
        #4;
        checkOutput("stray_wait_mem", {31'd0, waitMem}, 32'd0);
        @(negedge clk);
        ackStray = 1'b0;
        checkOutput("stray_dmem_req", {31'd0, dmemReq}, 32'd0);
        checkOutput("stray_result_mem", resultMem, 32'd0);
        checkOutput("stray_reg_write_mem", {31'd0, regWriteMem}, 32'd0);

        // Normal operation resumes after the abort
        applyStimulus("post_alu", 32'h0000_0042, 5'd31, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0000_0300, 1'b0,
                      18'h0, 0, 32'h0, 32'h0000_0042, 1'b1, 0);
        applyIdle(3);
        checkOutput("sb_drained", sbQ.size(), 32'd0);
        checkOutput("mem_drained", memQ.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
